// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bundle for the shared 4:1 mux: requests/data in, grant/select/output back.
// master = requester blocks, slave = the arbiter.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       y;

    modport master (
        output req,
        output d,
        input  gnt,
        input  sel,
        input  valid,
        input  y
    );

    modport slave (
        input  req,
        input  d,
        output gnt,
        output sel,
        output valid,
        output y
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit mux; grant held up to MAX_HOLD cycles, 1-cycle grant latency.
// Optional macro MUX_OUT_REG_EN registers y/valid (one extra cycle of output latency); no backpressure, requesters hold req.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   arb
);

    localparam int CNT_W = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [3:0]         r_gnt;
    logic [1:0]         r_sel;
    logic [1:0]         r_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic [2:0]         w_idle_pick;
    logic [2:0]         w_rel_pick;
    logic               w_expire;
    logic               w_release;
    logic               w_grant_act;
    logic               w_mux_out;

    // Returns {found, index} of the first set request, scanning start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = start + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Scanning from sel+1 puts the current holder last, so it only wins when alone.
    assign w_idle_pick = rr_pick(arb.req, r_ptr);
    assign w_rel_pick  = rr_pick(arb.req, r_sel + 2'd1);
    assign w_expire    = (r_cnt == CNT_W'(MAX_HOLD - 1));
    assign w_release   = !arb.req[r_sel] || w_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_pick[2]) begin
                        r_gnt   <= 4'b0001 << w_idle_pick[1:0];
                        r_sel   <= w_idle_pick[1:0];
                        r_cnt   <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_ptr <= r_sel + 2'd1;
                        r_cnt <= '0;
                        if (w_rel_pick[2]) begin
                            r_gnt <= 4'b0001 << w_rel_pick[1:0];
                            r_sel <= w_rel_pick[1:0];
                        end else begin
                            r_gnt   <= 4'b0000;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

    assign w_grant_act = (r_state == ST_GRANT);
    assign w_mux_out   = w_grant_act ? arb.d[r_sel] : 1'b0;

    assign arb.gnt = r_gnt;
    assign arb.sel = r_sel;

`ifdef MUX_OUT_REG_EN
    logic r_valid;
    logic r_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_y     <= 1'b0;
        end else begin
            r_valid <= w_grant_act;
            r_y     <= w_mux_out;
        end
    end

    assign arb.valid = r_valid;
    assign arb.y     = r_y;
`else
    assign arb.valid = w_grant_act;
    assign arb.y     = w_mux_out;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios with literal expectations, then random traffic vs. a behavioural model.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who holds the mux (-1 = nobody), how many edges it has held, where the next idle search starts.
    int   m_holder = -1;
    int   m_held   = 0;
    int   m_ptr    = 0;
    logic m_vreg   = 1'b0;
    logic m_yreg   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int scan(input logic [3:0] rq, input int start);
        int r;
        r = -1;
        for (int k = 0; k < 4; k++)
            if (r < 0 && rq[(start + k) % 4]) r = (start + k) % 4;
        return r;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_holder = -1;
            m_held   = 0;
            m_ptr    = 0;
            m_vreg   = 1'b0;
            m_yreg   = 1'b0;
            return;
        end
        m_vreg = (m_holder >= 0);
        m_yreg = (m_holder >= 0) ? bus.d[m_holder] : 1'b0;
        if (m_holder < 0) begin
            m_holder = scan(bus.req, m_ptr);
            m_held   = 0;
        end else if (!bus.req[m_holder] || (m_held + 1 == MAX_HOLD)) begin
            m_ptr    = (m_holder + 1) % 4;
            m_holder = scan(bus.req, m_holder + 1);
            m_held   = 0;
        end else begin
            m_held++;
        end
    endtask

    function automatic logic exp_valid();
`ifdef MUX_OUT_REG_EN
        return m_vreg;
`else
        return (m_holder >= 0);
`endif
    endfunction

    function automatic logic exp_y();
`ifdef MUX_OUT_REG_EN
        return m_yreg;
`else
        return (m_holder >= 0) ? bus.d[m_holder] : 1'b0;
`endif
    endfunction

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_holder < 0) ? 4'b0000 : (4'b0001 << m_holder);
        chk("model_gnt", bus.gnt, eg);
        chk("model_valid", bus.valid, exp_valid());
        chk("model_y", bus.y, exp_y());
        if (m_holder >= 0) chk("model_sel", bus.sel, m_holder);
    endtask

    // One clock: drive at negedge, check combinational y, step model at posedge, check at next negedge.
    task automatic cycle(input logic r, input logic [3:0] rq, input logic [3:0] dd);
        rst     = r;
        bus.req = rq;
        bus.d   = dd;
        #1;
        chk("comb_y", bus.y, exp_y());
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic       r;
        logic [3:0] rq;
        bus.req = 4'b0000;
        bus.d   = 4'b0000;
        @(negedge clk);

        // Reset with all requesting: nothing granted until rst falls
        cycle(1'b1, 4'b1111, 4'b0000);
        cycle(1'b1, 4'b1111, 4'b0000);
        chk("rst_gnt", bus.gnt, 4'b0000);
        chk("rst_sel", bus.sel, 2'b00);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_y", bus.y, 1'b0);

        // Rotation: each requester keeps the mux for MAX_HOLD cycles, no gaps
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 4'b1111, 4'($urandom_range(0, 15)));
            chk($sformatf("rot_gnt_%0d", i), bus.gnt, 4'b0001 << ((i / 4) % 4));
        end

        // Single requester
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0100, 4'b0100);
        chk("single_gnt", bus.gnt, 4'b0100);
        chk("single_sel", bus.sel, 2'b10);
`ifndef MUX_OUT_REG_EN
        chk("single_valid", bus.valid, 1'b1);
        chk("single_y", bus.y, 1'b1);
`endif
        cycle(1'b0, 4'b0100, 4'b0100);
        chk("single_valid2", bus.valid, 1'b1);
        chk("single_y2", bus.y, 1'b1);
        cycle(1'b0, 4'b0000, 4'b0100);
        chk("single_drop_gnt", bus.gnt, 4'b0000);
`ifndef MUX_OUT_REG_EN
        chk("single_drop_valid", bus.valid, 1'b0);
`endif

        // Early release skips idle requesters 1 and 2
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b1001, 4'b0000);
        chk("skip_first", bus.gnt, 4'b0001);
        cycle(1'b0, 4'b1001, 4'b0000);
        cycle(1'b0, 4'b1000, 4'b0000);
        chk("skip_gnt", bus.gnt, 4'b1000);
        chk("skip_sel", bus.sel, 2'b11);

        // Reset in the middle of a grant
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0010, 4'b0000);
        cycle(1'b0, 4'b0010, 4'b0000);
        cycle(1'b1, 4'b0010, 4'b0000);
        chk("midrst_gnt", bus.gnt, 4'b0000);
        chk("midrst_valid", bus.valid, 1'b0);
        cycle(1'b0, 4'b0010, 4'b0000);
        chk("midrst_regrant", bus.gnt, 4'b0010);

        // Data path following d[1]
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0010, 4'b0010);
        cycle(1'b0, 4'b0010, 4'b0010);
        chk("data_y1", bus.y, 1'b1);
        bus.d = 4'b0000;
        #1;
`ifdef MUX_OUT_REG_EN
        chk("data_y_lag", bus.y, 1'b1);
`else
        chk("data_y_now", bus.y, 1'b0);
`endif
        cycle(1'b0, 4'b0010, 4'b0000);
        chk("data_y0", bus.y, 1'b0);

        // Random traffic against the model
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            cycle(r, rq, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 single-bit mux between four requesters.
- Requester i raises req[i] and presents its data bit on d[i].
- The arbiter grants one requester at a time and drives the mux select. The shared output y carries the granted requester's bit, qualified by valid.
- Sits between lab requester blocks and the shared 4:1 mux datapath; the mux function is instantiated inside.

Parameters:
- MAX_HOLD, 4, max consecutive cycles one grant is held before forced rotation; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] = requester i wants the mux.
- d  input  4  data bits; d[i] from requester i.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  mux select, registered; index of granted requester.
- valid  output  1  high when y carries granted data.
- y  output  1  shared mux output, d[sel] while valid, else 0.

Behaviour:
- Reset (rst=1 at posedge, including mid-grant):
  - state=IDLE, gnt=0000, sel=00, valid=0, y=0, ptr=0, hold counter cnt=0.
  - Reset takes priority over all other events.
- State IDLE:
  - gnt=0, valid=0.
  - If req!=0 at posedge, pick the first index with req set, searching ptr, ptr+1, ... mod 4.
  - Load gnt/sel, set cnt=0, go to GRANT.
  - Grant latency: 1 cycle from req seen to gnt high.
- State GRANT:
  - valid=1; y=d[sel] combinationally (same cycle as d).
  - Each posedge, cnt increments.
  - Release condition: req[sel]==0 OR cnt==MAX_HOLD-1.
- On release:
  - ptr=(sel+1) mod 4.
  - Choose the next winner from the current req, searching sel+1, sel+2, sel+3, sel, so the current holder is considered last.
  - Winner found: load new gnt/sel, cnt=0, stay in GRANT. Handover is back-to-back with no idle cycle.
  - No winner: go to IDLE, gnt=0.
- Simultaneous events:
  - req[sel] drop and hold expiry in the same cycle are one release.
  - New requests arriving during GRANT are only evaluated at release.
- With MAX_HOLD=1, the grant rotates every cycle while multiple requesters are active. A lone requester is re-granted each cycle, and gnt stays continuously high.
- Only gnt, sel, valid and (macro on) y are registered. y is 0 whenever valid=0.
- gnt is always one-hot or zero and always consistent with sel.

Optional Feature:
- Macro: MUX_OUT_REG_EN.
- Defined:
  - y and valid are registered: y(t+1)=d[sel](t), valid(t+1)=(state==GRANT)(t).
  - This adds 1 cycle of output latency; gnt/sel timing is unchanged.
  - Reset clears both to 0.
- Undefined: y is combinational from d and sel as above, and valid equals (state==GRANT).

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, sel=00, valid=0, y=0. After rst falls, gnt=0001 one cycle later.
- Single requester: req=0100, d=0100 -> next cycle gnt=0100, sel=10, valid=1, y=1. Then drop req -> next cycle gnt=0000, valid=0.
- Round-robin rotation: MAX_HOLD=4, req=1111 held -> gnt sequence 0001 for 4 cycles, then 0010, 0100, 1000, 0001, each for 4 cycles, with no idle gaps.
- Early release with skip: req=1001, holder 0 drops req after 2 cycles -> next cycle gnt=1000, sel=11. Requesters 1 and 2 are skipped.
- Mid-grant reset: req=0010 granted, assert rst at cycle 2 of hold -> next edge gnt=0000, valid=0, ptr=0. Re-grant after rst release is gnt=0010.
- Data path: grant requester 1, toggle d=0010 then 0000 -> y follows 1 then 0 same cycle. With MUX_OUT_REG_EN, y follows one cycle later.
